dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (DMEM) in the pipelined RISC-V core.
- Shares DMEM between the pipeline load/store stage (cpu port) and a program loader/DMA engine (ext port).
- Per access: selects a winner, holds address, data and control stable for a programmable number of cycles, then returns read data or a write acknowledgement.
- Rejects accesses that are not word-aligned, because DMEM only services byte offset 0.

Parameters:
- WAIT_CYCLES, 1, cycles the memory controls are held in ACCESS before DataR is sampled (legal range 1..15).
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = cpu always wins a tie.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  cpu request, held high until cpu_gnt
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_wsel  in  2  store size: 00 SB, 01 SH, 10 SW
- cpu_rsel  in  3  load type: 000 LB, 010 LH, 011 LW, 100 LBU, 101 LHU
- cpu_gnt  out  1  one-cycle pulse; request accepted
- cpu_ack  out  1  one-cycle pulse; access complete
- cpu_rdata  out  32  load data, valid with cpu_ack
- cpu_err  out  1  misaligned flag, valid with cpu_ack
- ext_req, ext_we, ext_addr, ext_wdata, ext_wsel, ext_rsel, ext_gnt, ext_ack, ext_rdata, ext_err: same as cpu_*, for the loader/DMA port
- mem_addr  out  32  to DMEM Addr
- mem_wdata  out  32  to DMEM DataW
- mem_rw  out  1  to DMEM MemRW; 1 = write
- mem_wsel  out  2  to DMEM WSel
- mem_rsel  out  3  to DMEM RSel
- mem_rdata  in  32  from DMEM DataR

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE, rr_last = ext (so cpu wins the first tie).
  - All gnt, ack and err outputs 0; all rdata 0.
  - mem_rw 0, mem_addr 0, mem_wdata 0, mem_wsel 2'b10, mem_rsel 3'b011.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any req is high, pick a winner. A single requester wins. On a tie, FIXED_PRIO=1 gives cpu; FIXED_PRIO=0 gives the port that is not rr_last.
  - The winner's gnt is combinational, high for this cycle only.
  - At the clock edge: latch the winner's addr, wdata, wsel, rsel and we into the mem_* registers, record owner, update rr_last, load the wait counter with WAIT_CYCLES-1, go to ACCESS.
  - Misaligned request (addr[1:0] != 0): latch and grant as normal, but force mem_rw = 0 and set the pending err flag.
- ACCESS:
  - mem_* outputs are registered and stable. mem_rw = latched we, unless err is pending.
  - The counter decrements each cycle. When it reaches 0, at the edge: capture mem_rdata (load, no err) or 0 (store or err), deassert mem_rw, go to DONE.
- DONE:
  - The owner's ack is high for one cycle. rdata and err are valid, and are held until that port's next ack.
  - Go to IDLE. No grant is issued in DONE.
- Latency: gnt in cycle N; ack in cycle N+1+WAIT_CYCLES. Minimum issue interval is WAIT_CYCLES+2 cycles.
- mem_rw is 1 only inside ACCESS. mem_addr does not change while mem_rw = 1, because DMEM writes combinationally.
- The non-owner's req is ignored outside IDLE and stays pending; its gnt stays 0.
- A requester may drop req after gnt. Changing addr, wdata or we after gnt has no effect.
- Reset mid-operation: mem_rw drops to 0 asynchronously, the access is aborted, and no ack is issued.
- mem_wsel and mem_rsel are passed through verbatim. Illegal codes are not checked.

Decomposition:
- Shared package dmem_pkg:
  - state enum (IDLE, ACCESS, DONE)
  - WSEL_SB/SH/SW constants
  - RSEL_LB/LH/LW/LBU/LHU constants
  - port-id constant (PORT_CPU = 0, PORT_EXT = 1)
- One natural sub-module: rr_arb2, a two-requester round-robin/fixed-priority picker with an rr_last register. It is combinational grant plus the pointer update.
- FSM, latch registers and response registers live in dmem_arbiter.

Test Plan:
- Single cpu SW, addr 0x100, data 0xDEADBEEF, WAIT_CYCLES=1: cpu_gnt at N, mem_rw high only in N+1, cpu_ack at N+2. A following LW from 0x100 returns cpu_rdata = 0xDEADBEEF, cpu_err = 0.
- cpu and ext req together in IDLE from reset, FIXED_PRIO=0: cpu granted first, ext granted on the next IDLE. Repeat the tie: order alternates cpu/ext. With FIXED_PRIO=1, cpu always wins.
- ext LB from 0x102 (misaligned): ext_gnt pulses, mem_rw stays 0 throughout, ext_ack with ext_err = 1, ext_rdata = 0, memory contents unchanged.
- Pre-load word 0x200 = 0x000080F0. LB returns 0xFFFFFFF0, LBU returns 0x000000F0, LH returns 0xFFFF80F0, LHU returns 0x000080F0. Then SB 0x11 and readback LW returns 0x00008011.
- WAIT_CYCLES=3, cpu SW in flight: assert rst_n = 0 during the second ACCESS cycle. mem_rw drops immediately, no ack is issued, and after release state is IDLE with all outputs at reset values.
- ext holds req during a cpu access: ext_gnt stays 0 until the cycle after cpu_ack, then pulses exactly once.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and encodings for the DMEM arbiter slice: FSM states,
// store/load size codes and port identifiers.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] WSEL_SB = 2'b00;
    localparam logic [1:0] WSEL_SH = 2'b01;
    localparam logic [1:0] WSEL_SW = 2'b10;

    localparam logic [2:0] RSEL_LB  = 3'b000;
    localparam logic [2:0] RSEL_LH  = 3'b010;
    localparam logic [2:0] RSEL_LW  = 3'b011;
    localparam logic [2:0] RSEL_LBU = 3'b100;
    localparam logic [2:0] RSEL_LHU = 3'b101;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_EXT = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester picker: combinational grant, round-robin or cpu-first on a tie,
// with the last-winner pointer updated whenever a grant is issued.
module rr_arb2
    import dmem_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_cpu,
    input  logic req_ext,
    output logic gnt_cpu,
    output logic gnt_ext
);

    logic rr_last_reg;
    logic rr_last_next;
    logic pick;

    always_comb begin
        pick = PORT_CPU;
        if (req_cpu && req_ext) begin
            pick = FIXED_PRIO ? PORT_CPU : ~rr_last_reg;
        end else if (req_ext) begin
            pick = PORT_EXT;
        end
        gnt_cpu      = en && req_cpu && (pick == PORT_CPU);
        gnt_ext      = en && req_ext && (pick == PORT_EXT);
        rr_last_next = rr_last_reg;
        if (gnt_cpu || gnt_ext) begin
            rr_last_next = pick;
        end
    end

    // Starting at ext lets cpu win the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_reg <= PORT_EXT;
        end else begin
            rr_last_reg <= rr_last_next;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between the cpu load/store stage and the ext
// loader/DMA port; each access is granted, held for WAIT_CYCLES, then acked.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int FIXED_PRIO  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_wsel,
    input  logic [2:0]  cpu_rsel,
    output logic        cpu_gnt,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [1:0]  ext_wsel,
    input  logic [2:0]  ext_rsel,
    output logic        ext_gnt,
    output logic        ext_ack,
    output logic [31:0] ext_rdata,
    output logic        ext_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    output logic [1:0]  mem_wsel,
    output logic [2:0]  mem_rsel,
    input  logic [31:0] mem_rdata
);

    state_t      state_reg, state_next;
    logic        owner_reg;
    logic        err_pend_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] mem_addr_reg, mem_wdata_reg;
    logic        mem_rw_reg;
    logic [1:0]  mem_wsel_reg;
    logic [2:0]  mem_rsel_reg;
    logic [31:0] cpu_rdata_reg, ext_rdata_reg;
    logic        cpu_err_reg, ext_err_reg;

    logic        grant;
    logic        sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_wsel;
    logic [2:0]  sel_rsel;
    logic        sel_misaligned;
    logic [31:0] cap_data;

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO != 0)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state_reg == IDLE),
        .req_cpu (cpu_req),
        .req_ext (ext_req),
        .gnt_cpu (cpu_gnt),
        .gnt_ext (ext_gnt)
    );

    assign grant          = cpu_gnt | ext_gnt;
    assign sel_we         = ext_gnt ? ext_we    : cpu_we;
    assign sel_addr       = ext_gnt ? ext_addr  : cpu_addr;
    assign sel_wdata      = ext_gnt ? ext_wdata : cpu_wdata;
    assign sel_wsel       = ext_gnt ? ext_wsel  : cpu_wsel;
    assign sel_rsel       = ext_gnt ? ext_rsel  : cpu_rsel;
    assign sel_misaligned = (sel_addr[1:0] != 2'b00);

    // A store (mem_rw still high) or a rejected access returns zero data.
    assign cap_data = (mem_rw_reg || err_pend_reg) ? 32'd0 : mem_rdata;

    always_comb begin
        state_next = state_reg;
        cpu_ack    = 1'b0;
        ext_ack    = 1'b0;
        case (state_reg)
            IDLE:    if (grant) state_next = ACCESS;
            ACCESS:  if (cnt_reg == 4'd0) state_next = DONE;
            DONE: begin
                state_next = IDLE;
                cpu_ack    = (owner_reg == PORT_CPU);
                ext_ack    = (owner_reg == PORT_EXT);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= PORT_CPU;
            err_pend_reg  <= 1'b0;
            cnt_reg       <= 4'd0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            mem_rw_reg    <= 1'b0;
            mem_wsel_reg  <= WSEL_SW;
            mem_rsel_reg  <= RSEL_LW;
            cpu_rdata_reg <= 32'd0;
            ext_rdata_reg <= 32'd0;
            cpu_err_reg   <= 1'b0;
            ext_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        mem_addr_reg  <= sel_addr;
                        mem_wdata_reg <= sel_wdata;
                        mem_wsel_reg  <= sel_wsel;
                        mem_rsel_reg  <= sel_rsel;
                        mem_rw_reg    <= sel_we && !sel_misaligned;
                        err_pend_reg  <= sel_misaligned;
                        owner_reg     <= ext_gnt ? PORT_EXT : PORT_CPU;
                        cnt_reg       <= 4'(WAIT_CYCLES - 1);
                    end
                end
                ACCESS: begin
                    if (cnt_reg == 4'd0) begin
                        mem_rw_reg <= 1'b0;
                        if (owner_reg == PORT_CPU) begin
                            cpu_rdata_reg <= cap_data;
                            cpu_err_reg   <= err_pend_reg;
                        end else begin
                            ext_rdata_reg <= cap_data;
                            ext_err_reg   <= err_pend_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_rw    = mem_rw_reg;
    assign mem_wsel  = mem_wsel_reg;
    assign mem_rsel  = mem_rsel_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign cpu_err   = cpu_err_reg;
    assign ext_rdata = ext_rdata_reg;
    assign ext_err   = ext_err_reg;

endmodule
